// File: rtl/s1_pkg.sv
// Shared types and constants for the S1 selection encoder.
package s1_pkg;

    localparam int unsigned SEL_W = 2;

    typedef enum logic [1:0] {BROWSE, CONFIRM, WAIT_ACK, LOCKED} s1_state_t;

    typedef enum logic [SEL_W-1:0] {OPT_0, OPT_1, OPT_2, OPT_3} s1_code_t;

    // Step the selection code, wrapping at the last legal option.
    function automatic logic [SEL_W-1:0] next_code(input logic [SEL_W-1:0] code,
                                                   input int unsigned      num_opts);
        if (32'(code) + 32'd1 >= num_opts)
            return OPT_0;
        return code + 2'd1;
    endfunction

endpackage

// File: rtl/s1_debounce.sv
// Two-flop synchronizer, consecutive-sample debouncer and press (rise) pulse
// for one raw panel button.
module s1_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise
);

    logic       r_sync1;
    logic       r_sync2;
    logic       r_level;
    logic       r_level_d;
    logic [7:0] r_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= i_raw;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            // Any sample agreeing with the accepted level restarts the run.
            if (r_sync2 != r_level) begin
                if (r_cnt == 8'(DEBOUNCE_CYCLES - 1)) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_level & ~r_level_d;

endmodule

// File: rtl/s1_select_encoder.sv
// NEXT/OK panel buttons to 2-bit S1 selection code with confirm pulse and
// brew lock. Optional NEXT auto-repeat: define S1_AUTOREPEAT_EN.
module s1_select_encoder
    import s1_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned NUM_OPTIONS     = 4,
    parameter int unsigned REPEAT_CYCLES   = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             btn_next,
    input  logic             btn_ok,
    input  logic             busy,
    output logic             saida1Contador,
    output logic             saida2Contador,
    output logic             sel_valid,
    output logic [SEL_W-1:0] sel_code
);

    if (DEBOUNCE_CYCLES == 0 || DEBOUNCE_CYCLES > 255 || NUM_OPTIONS < 2 ||
        NUM_OPTIONS > 4 || REPEAT_CYCLES == 0 || REPEAT_CYCLES > 65535) begin : g_bad_cfg
        $error("s1_select_encoder: parameter out of range");
    end

    s1_state_t        r_state;
    s1_state_t        w_state_next;
    logic [SEL_W-1:0] r_code;
    logic [SEL_W-1:0] w_code_next;
    logic             w_next_level;
    logic             w_next_rise;
    logic             w_next_evt;
    logic             w_ok_rise;
    logic             w_unused_ok_level;

    s1_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
        .clock   (clock),
        .reset   (reset),
        .i_raw   (btn_next),
        .o_level (w_next_level),
        .o_rise  (w_next_rise)
    );

    s1_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ok (
        .clock   (clock),
        .reset   (reset),
        .i_raw   (btn_ok),
        .o_level (w_unused_ok_level),
        .o_rise  (w_ok_rise)
    );

`ifdef S1_AUTOREPEAT_EN
    logic [15:0] r_rpt_cnt;
    logic        w_rpt_fire;

    // Counter is 0 in the press-event cycle, so the first repeat lands
    // REPEAT_CYCLES later; reloading with 1 keeps the same period after that.
    assign w_rpt_fire = w_next_level && (r_rpt_cnt == 16'(REPEAT_CYCLES));
    assign w_next_evt = w_next_rise | w_rpt_fire;

    always_ff @(posedge clock) begin
        if (reset || !w_next_level || r_state != BROWSE)
            r_rpt_cnt <= '0;
        else if (w_rpt_fire)
            r_rpt_cnt <= 16'd1;
        else
            r_rpt_cnt <= r_rpt_cnt + 16'd1;
    end
`else
    logic w_unused_next_level;

    assign w_unused_next_level = w_next_level;
    assign w_next_evt          = w_next_rise;
`endif

    always_comb begin
        w_state_next = r_state;
        w_code_next  = r_code;
        sel_valid    = 1'b0;
        sel_code     = '0;
        case (r_state)
            BROWSE: begin
                if (w_ok_rise)
                    w_state_next = CONFIRM;
                else if (w_next_evt)
                    w_code_next = next_code(r_code, NUM_OPTIONS);
            end
            CONFIRM: begin
                sel_valid    = 1'b1;
                sel_code     = r_code;
                w_state_next = WAIT_ACK;
            end
            WAIT_ACK: if (busy) w_state_next = LOCKED;
            LOCKED:   if (!busy) w_state_next = BROWSE;
            default:  w_state_next = BROWSE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= BROWSE;
            r_code  <= OPT_0;
        end else begin
            r_state <= w_state_next;
            r_code  <= w_code_next;
        end
    end

    assign saida1Contador = r_code[1];
    assign saida2Contador = r_code[0];

endmodule

// File: tb/tb_s1_select_encoder.sv
// Scoreboard bench for s1_select_encoder: NUM_OPTIONS=4 and =3 instances
// share stimulus; a window-based reference model predicts timestamped events.
module tb_s1_select_encoder;

    localparam int unsigned D = 4;
    localparam int unsigned R = 16;

    logic       clock = 1'b0;
    logic       reset;
    logic       btn_next;
    logic       btn_ok;
    logic       busy;
    logic       s1_a, s2_a, sv_a;
    logic [1:0] sc_a;
    logic       s1_b, s2_b, sv_b;
    logic [1:0] sc_b;

    always #5 clock = ~clock;

    s1_select_encoder #(.DEBOUNCE_CYCLES(D), .NUM_OPTIONS(4), .REPEAT_CYCLES(R)) u_dut4 (
        .clock(clock), .reset(reset), .btn_next(btn_next), .btn_ok(btn_ok), .busy(busy),
        .saida1Contador(s1_a), .saida2Contador(s2_a), .sel_valid(sv_a), .sel_code(sc_a)
    );

    s1_select_encoder #(.DEBOUNCE_CYCLES(D), .NUM_OPTIONS(3), .REPEAT_CYCLES(R)) u_dut3 (
        .clock(clock), .reset(reset), .btn_next(btn_next), .btn_ok(btn_ok), .busy(busy),
        .saida1Contador(s1_b), .saida2Contador(s2_b), .sel_valid(sv_b), .sel_code(sc_b)
    );

    typedef struct { int inst; int kind; int cyc; int val; } exp_t;
    typedef enum { M_BROWSE, M_CONFIRM, M_WAIT, M_LOCKED } mode_t;

    exp_t  exp_q[$];
    int    checks   = 0;
    int    failures = 0;
    int    cyc      = 0;
    int    rst_cyc  = -1;
    int    opts[2]  = '{4, 3};
    int    code_m[2] = '{0, 0};
    int    last_code[2] = '{0, 0};
    mode_t mode = M_BROWSE;
    bit    lvl_n, lvl_n_prev, lvl_o, lvl_o_prev;
    bit    hn[$];
    bit    ho[$];
`ifdef S1_AUTOREPEAT_EN
    int    age = 0;
`endif

    function automatic void push(input int inst, input int kind, input int val);
        exp_t e;
        e.inst = inst; e.kind = kind; e.cyc = cyc; e.val = val;
        exp_q.push_back(e);
    endfunction

    // Level flips when the D synchronized samples seen so far all oppose it;
    // h holds raw samples up to the previous edge, 2 edges of sync lag.
    function automatic bit settle(input bit h[$], input bit lvl);
        if (h.size() < int'(D) + 1) return lvl;
        for (int k = 0; k < int'(D); k++)
            if (h[k] == lvl) return lvl;
        return !lvl;
    endfunction

    task automatic model_step();
        bit ev_next, ev_ok;
        cyc++;
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                if (code_m[i] != 0) push(i, 0, 0);
                code_m[i] = 0;
            end
            mode = M_BROWSE;
            lvl_n = 0; lvl_n_prev = 0; lvl_o = 0; lvl_o_prev = 0;
            hn.delete(); ho.delete();
`ifdef S1_AUTOREPEAT_EN
            age = 0;
`endif
            rst_cyc = cyc;
            return;
        end
        ev_next = lvl_n && !lvl_n_prev;
        ev_ok   = lvl_o && !lvl_o_prev;
`ifdef S1_AUTOREPEAT_EN
        if (lvl_n && age != 0 && (age % int'(R)) == 0) ev_next = 1;
        age = (lvl_n && mode == M_BROWSE) ? age + 1 : 0;
`endif
        case (mode)
            M_BROWSE: begin
                if (ev_ok) begin
                    mode = M_CONFIRM;
                    for (int i = 0; i < 2; i++) push(i, 1, code_m[i]);
                end else if (ev_next) begin
                    for (int i = 0; i < 2; i++) begin
                        code_m[i] = (code_m[i] + 1) % opts[i];
                        push(i, 0, code_m[i]);
                    end
                end
            end
            M_CONFIRM: mode = M_WAIT;
            M_WAIT:    if (busy) mode = M_LOCKED;
            default:   if (!busy) mode = M_BROWSE;
        endcase
        lvl_n_prev = lvl_n;
        lvl_o_prev = lvl_o;
        lvl_n = settle(hn, lvl_n);
        lvl_o = settle(ho, lvl_o);
        hn.push_back(btn_next);
        ho.push_back(btn_ok);
        if (hn.size() > int'(D) + 1) void'(hn.pop_front());
        if (ho.size() > int'(D) + 1) void'(ho.pop_front());
    endtask

    initial forever begin
        @(posedge clock);
        model_step();
    end

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, got, want);
        end
    endtask

    function automatic int find_exp(input int inst, input int kind);
        for (int k = 0; k < exp_q.size(); k++)
            if (exp_q[k].inst == inst && exp_q[k].kind == kind) return k;
        return -1;
    endfunction

    task automatic monitor_inst(input int i, input logic [1:0] code, input logic sv,
                                input logic [1:0] sc);
        int idx;
        for (int k = exp_q.size() - 1; k >= 0; k--) begin
            if (exp_q[k].inst == i && exp_q[k].cyc < cyc) begin
                checks++; failures++;
                $display("FAIL missed_event inst=%0d kind=%0d due_cyc=%0d expected=%0d now=%0d",
                         i, exp_q[k].kind, exp_q[k].cyc, exp_q[k].val, cyc);
                exp_q.delete(k);
            end
        end
        if (rst_cyc == cyc) begin
            check($sformatf("reset_code[%0d]", i), int'(code), 0);
            check($sformatf("reset_sel_valid[%0d]", i), int'(sv), 0);
            check($sformatf("reset_sel_code[%0d]", i), int'(sc), 0);
        end
        if (code !== 2'(last_code[i])) begin
            idx = find_exp(i, 0);
            if (idx < 0) begin
                checks++; failures++;
                $display("FAIL unexpected_code_change inst=%0d cyc=%0d got=%0d expected=%0d",
                         i, cyc, code, last_code[i]);
            end else begin
                check($sformatf("code_value[%0d]", i), int'(code), exp_q[idx].val);
                check($sformatf("code_time[%0d]", i), cyc, exp_q[idx].cyc);
                exp_q.delete(idx);
            end
            last_code[i] = int'(code);
        end
        if (sv !== 1'b0) begin
            idx = find_exp(i, 1);
            if (idx < 0) begin
                checks++; failures++;
                $display("FAIL unexpected_sel_valid inst=%0d cyc=%0d got=%0d expected=0", i, cyc, sv);
            end else begin
                check($sformatf("sel_code[%0d]", i), int'(sc), exp_q[idx].val);
                check($sformatf("sel_time[%0d]", i), cyc, exp_q[idx].cyc);
                exp_q.delete(idx);
            end
        end
    endtask

    initial forever begin
        @(negedge clock);
        if (rst_cyc >= 0) begin
            monitor_inst(0, {s1_a, s2_a}, sv_a, sc_a);
            monitor_inst(1, {s1_b, s2_b}, sv_b, sc_b);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1; tick(n); reset = 1'b0; tick(3);
    endtask

    task automatic press_next(input int hold, input int gap);
        btn_next = 1'b1; tick(hold); btn_next = 1'b0; tick(gap);
    endtask

    initial begin
        int sel;
        btn_next = 1'b0; btn_ok = 1'b0; busy = 1'b0;
        do_reset(2);

        // single press: change exactly 7 edges after the raw rise
        btn_next = 1'b1;
        tick(6); check("latency_before", int'({s1_a, s2_a}), 0);
        tick(1); check("latency_at_7", int'({s1_a, s2_a}), 1);
        tick(13); btn_next = 1'b0; tick(12);
        check("single_no_repeat", int'({s1_a, s2_a}), 1);

        // bounce rejection
        do_reset(2);
        for (int k = 0; k < 15; k++) begin btn_next = ~btn_next; tick(2); end
        btn_next = 1'b0; tick(12);
        check("bounce_stays", int'({s1_a, s2_a}), 0);

        // wrap for 4 and 3 options
        for (int k = 0; k < 4; k++) begin
            press_next(8, 8);
            check("wrap4", int'({s1_a, s2_a}), (k + 1) % 4);
            check("wrap3", int'({s1_b, s2_b}), (k + 1) % 3);
        end

        // simultaneous NEXT+OK at code 10, then lock and release
        do_reset(2);
        press_next(8, 8); press_next(8, 8);
        btn_next = 1'b1; btn_ok = 1'b1; tick(10);
        btn_next = 1'b0; btn_ok = 1'b0; busy = 1'b1;
        tick(1); press_next(8, 1); busy = 1'b0; tick(10);
        check("locked_code4", int'({s1_a, s2_a}), 2);
        check("locked_code3", int'({s1_b, s2_b}), 2);
        press_next(8, 8);
        check("after_lock4", int'({s1_a, s2_a}), 3);
        check("after_lock3", int'({s1_b, s2_b}), 0);

`ifdef S1_AUTOREPEAT_EN
        do_reset(2);
        btn_next = 1'b1; tick(47); btn_next = 1'b0; tick(20);
        check("autorepeat4", int'({s1_a, s2_a}), 3);
        check("autorepeat3", int'({s1_b, s2_b}), 0);
`endif

        // randomized traffic with occasional mid-run resets
        for (int n = 0; n < 200; n++) begin
            busy = 1'($urandom_range(0, 1));
            sel  = int'($urandom_range(0, 9));
            case (sel)
                0, 1, 2, 3: press_next(int'($urandom_range(1, 12)), int'($urandom_range(1, 10)));
                4, 5: begin
                    btn_ok = 1'b1; tick(int'($urandom_range(1, 12)));
                    btn_ok = 1'b0; tick(int'($urandom_range(1, 10)));
                end
                6: for (int k = 0; k < int'($urandom_range(2, 10)); k++) begin
                    btn_next = 1'($urandom_range(0, 1));
                    btn_ok   = 1'($urandom_range(0, 1));
                    tick(int'($urandom_range(1, 5)));
                end
                7: begin
                    btn_next = 1'b1; btn_ok = 1'b1; tick(int'($urandom_range(5, 12)));
                    btn_next = 1'b0; btn_ok = 1'b0; tick(int'($urandom_range(1, 8)));
                end
                8: tick(int'($urandom_range(1, 20)));
                default: if ($urandom_range(0, 2) == 0) begin
                    reset = 1'b1; tick(int'($urandom_range(1, 2))); reset = 1'b0;
                end else tick(3);
            endcase
        end
        btn_next = 1'b0; btn_ok = 1'b0; busy = 1'b0;
        tick(30);
        check("leftover_expectations", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/s1_select_encoder.md
# s1_select_encoder

Input-side counterpart of the S1 beverage-selection display decoder. Turns the raw front-panel NEXT and OK push-buttons into the 2-bit selection code `saida1Contador`/`saida2Contador` that drives the S1 seven-segment decoder. It also issues a one-cycle confirmed-selection pulse to the brew controller and freezes the code while a brew is in progress. It sits between the panel buttons and both the S1 display decoder and the brew FSM.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive stable synchronized samples required before a button level is accepted; range 1..255.
- `NUM_OPTIONS`, 4: number of selectable options; range 2..4; codes 0..NUM_OPTIONS-1.
- `REPEAT_CYCLES`, 16: auto-repeat period while NEXT is held; used only with `S1_AUTOREPEAT_EN`.
- `clock`  in  1  single clock; all state on rising edge.
- `reset`  in  1  synchronous, active-high.
- `btn_next`  in  1  raw NEXT button, asynchronous, active-high.
- `btn_ok`  in  1  raw OK button, asynchronous, active-high.
- `busy`  in  1  brew controller busy flag, synchronous to `clock`.
- `saida1Contador`  out  1  selection code MSB, to the S1 decoder.
- `saida2Contador`  out  1  selection code LSB, to the S1 decoder.
- `sel_valid`  out  1  one-cycle pulse: selection confirmed.
- `sel_code`  out  2  code captured at confirm; valid only with `sel_valid`.

## Operation
- Each button passes through a 2-flop synchronizer, then a debouncer:
  - The debounced level takes the synchronized value once that value has differed from the current debounced level for `DEBOUNCE_CYCLES` consecutive clocks.
  - Any mismatch break restarts the count.
- A press event is a 0→1 transition of the debounced level, lasting one cycle. Releases generate no event.
- The FSM has four states:
  - BROWSE: a NEXT event sets code to code+1. The code wraps from NUM_OPTIONS-1 to 0. An OK event goes to CONFIRM.
  - CONFIRM: lasts one cycle. `sel_valid`=1, `sel_code`=code. Goes to WAIT_ACK.
  - WAIT_ACK: stays until `busy`=1, then goes to LOCKED.
  - LOCKED: stays until `busy`=0, then goes to BROWSE.
- NEXT and OK events are ignored in every state except BROWSE. The code is frozen outside BROWSE.
- If NEXT and OK events occur in the same BROWSE cycle, OK wins. The confirmed code is the pre-increment value and the NEXT event is discarded.
- `busy` is ignored in BROWSE and CONFIRM.
- There is no timeout in WAIT_ACK. `reset` is the only escape.
- The code register holds a 2-bit value; with NUM_OPTIONS<4, values ≥ NUM_OPTIONS are unreachable.

## Timing
- Reset values:
  - code 00, so `saida1Contador`=0 and `saida2Contador`=0.
  - `sel_valid`=0, `sel_code`=00.
  - FSM in BROWSE.
  - Synchronizer flops, debounced levels and counters all 0.
- Assertion of `reset` mid-operation returns everything to the reset values on the next edge, in any state. A button held through reset must be debounced again from 0 and then produces one event.
- Latency from a steady raw rise to the code change: 2 (synchronizer) + `DEBOUNCE_CYCLES` + 1 edges. With the default, this is 7.
- Latency from an OK raw rise to `sel_valid`: the same 7 edges.
- `sel_valid` is high for exactly one cycle per confirm.
- `saida1Contador`/`saida2Contador` are registered outputs and change only on clock edges.

## Configuration
- `S1_AUTOREPEAT_EN` defined:
  - While the debounced NEXT level stays high in BROWSE, an extra NEXT event fires every `REPEAT_CYCLES` clocks, the first one `REPEAT_CYCLES` after the press event.
  - The repeat counter clears on release or on leaving BROWSE.
- Undefined: exactly one NEXT event per press, and the repeat counter is not built.

## Structure
- Package `s1_pkg` holds:
  - the state enum (BROWSE, CONFIRM, WAIT_ACK, LOCKED);
  - `SEL_W`=2;
  - the option code constants 0..3.
- Sub-module `s1_debounce` contains the synchronizer, debounce counter and rise-edge pulse. It is parameterized by `DEBOUNCE_CYCLES` and instantiated for NEXT and OK.

## Test plan
- Reset check: assert `reset` 2 cycles. Outputs must be 00, `sel_valid`=0 and `sel_code`=00 in the cycle after the first reset edge.
- Single press: hold `btn_next` for 20 cycles with the defaults and the macro off. Code goes 00→01 exactly 7 edges after the raw rise, with no further increment.
- Bounce rejection: toggle `btn_next` every 2 cycles for 30 cycles, then hold it low. Code stays 00.
- Wrap:
  - NUM_OPTIONS=4: 4 clean presses give 01, 10, 11, 00.
  - NUM_OPTIONS=3: 3 clean presses give 01, 10, 00.
- Confirm, lock and simultaneous events, with code=10:
  - Raise `btn_next` and `btn_ok` together. `sel_valid` pulses once with `sel_code`=10 and the code stays 10.
  - Raise `busy` 3 cycles later and hold it 10 cycles, pressing NEXT during that time. Code stays 10.
  - Drop `busy`. A subsequent NEXT press gives 11.
- Auto-repeat, with the macro defined and REPEAT_CYCLES=16: hold NEXT for 7+40 cycles. Code steps 00→01 (press event), then →10 at +16 and →11 at +32, and stops after release.
